// File: rtl/spi_slave_top.sv
// SPI target peripheral for the TRSQ8 CPU bus: oversampled sclk/mosi/ss_n,
// MSB-first byte shifting, and SSPCON/SSPTX/SSPRX registers on the 8-bit bus.
module spi_slave_top #(
  parameter int ADDR_LSB          = 0,
  parameter int OPT_MEM_ADDR_BITS = 1,
  parameter int SYNC_STAGES       = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic       miso_oe
);

  localparam int SelW = OPT_MEM_ADDR_BITS + 1;
  localparam logic [SelW-1:0] SEL_CON = SelW'(0);
  localparam logic [SelW-1:0] SEL_TX  = SelW'(1);
  localparam logic [SelW-1:0] SEL_RX  = SelW'(2);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t r_state, w_nextState;

  logic [SYNC_STAGES-1:0] r_sclkSync, r_mosiSync, r_ssSync;
  logic       r_sclkPrev, r_ssPrev;
  logic       r_cpol, r_cpha, r_en, r_rxValid, r_overrun, r_txLoaded;
  logic       r_modeCpol, r_modeCpha, r_miso;
  logic [7:0] r_tx, r_rx, r_shift;
  logic [2:0] r_cnt;

  logic [SelW-1:0] w_sel;
  logic [7:0] w_readData;
  logic w_sclkS, w_mosiS, w_ssS, w_ssFall, w_ssRise, w_lead, w_trail;
  logic w_enter, w_sample, w_shiftEdge, w_byteDone, w_busy, w_rd, w_unusedAddr;

  assign w_sel        = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign w_unusedAddr = ^addr;
  assign w_rd         = rd_en & ~wr_en;

  assign w_sclkS  = r_sclkSync[SYNC_STAGES-1];
  assign w_mosiS  = r_mosiSync[SYNC_STAGES-1];
  assign w_ssS    = r_ssSync[SYNC_STAGES-1];
  assign w_ssFall = r_ssPrev & ~w_ssS;
  assign w_ssRise = ~r_ssPrev & w_ssS;
  // Edges are judged against the mode latched at frame entry, not the live cpol
  assign w_lead   = (w_sclkS != r_modeCpol) && (r_sclkPrev == r_modeCpol);
  assign w_trail  = (w_sclkS == r_modeCpol) && (r_sclkPrev != r_modeCpol);

  assign miso_oe = w_busy;
  assign miso    = w_busy & r_miso;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclkSync <= '0;
      r_mosiSync <= '0;
      r_ssSync   <= '0;
      r_sclkPrev <= 1'b0;
      r_ssPrev   <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
      r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0], ss_n};
      r_sclkPrev <= w_sclkS;
      r_ssPrev   <= w_ssS;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_enter     = 1'b0;
    w_sample    = 1'b0;
    w_shiftEdge = 1'b0;
    w_byteDone  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_en && w_ssFall) begin
          w_nextState = ACTIVE;
          w_enter     = 1'b1;
        end
      end
      ACTIVE: begin
        w_busy = 1'b1;
        if (w_ssRise || !r_en) begin
          w_nextState = IDLE;
        end else begin
          w_sample    = r_modeCpha ? w_trail : w_lead;
          w_shiftEdge = r_modeCpha ? w_lead : w_trail;
          w_byteDone  = w_sample && (r_cnt == 3'd7);
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_readData = 8'h00;
    case (w_sel)
      SEL_CON: w_readData = {1'b0, r_txLoaded, r_overrun, r_rxValid, r_en, r_cpha, r_cpol, w_busy};
      SEL_TX:  w_readData = r_tx;
      SEL_RX:  w_readData = r_rx;
      default: w_readData = 8'h00;
    endcase
  end

  // Later assignments override earlier ones: CPU writes beat FSM clears, hardware sets beat CPU clears
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_en       <= 1'b0;
      r_rxValid  <= 1'b0;
      r_overrun  <= 1'b0;
      r_txLoaded <= 1'b0;
      r_modeCpol <= 1'b0;
      r_modeCpha <= 1'b0;
      r_miso     <= 1'b0;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_shift    <= 8'h00;
      r_cnt      <= 3'd0;
      dout       <= 8'h00;
    end else begin
      if (w_enter) begin
        r_shift    <= r_tx;
        r_txLoaded <= 1'b0;
        r_cnt      <= 3'd0;
        r_modeCpol <= r_cpol;
        r_modeCpha <= r_cpha;
        r_miso     <= r_cpha ? 1'b0 : r_tx[7];
      end
      if (w_sample) begin
        if (w_byteDone) begin
          r_rx       <= {r_shift[6:0], w_mosiS};
          r_shift    <= r_tx;
          r_txLoaded <= 1'b0;
          r_cnt      <= 3'd0;
        end else begin
          r_shift <= {r_shift[6:0], w_mosiS};
          r_cnt   <= r_cnt + 3'd1;
        end
      end
      if (w_shiftEdge) r_miso <= r_shift[7];

      if (wr_en) begin
        if (w_sel == SEL_CON) begin
          r_cpol <= din[1];
          r_cpha <= din[2];
          r_en   <= din[3];
          if (!din[5]) r_overrun <= 1'b0;
        end else if (w_sel == SEL_TX) begin
          r_tx       <= din;
          r_txLoaded <= 1'b1;
        end
      end
      if (w_rd) begin
        dout <= w_readData;
        if (w_sel == SEL_RX) r_rxValid <= 1'b0;
      end

      if (w_byteDone) begin
        r_rxValid <= 1'b1;
        if (r_rxValid && !(w_rd && w_sel == SEL_RX)) r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_top.sv
// Scoreboard bench for spi_slave_top: a bus-level register model plus a bit-banged
// SPI master; expectations are queued at issue time and popped by monitors.
module tb_spi_slave_top;

  localparam int HP   = 8;
  localparam int SYNC = 2;

  logic       clk, reset_n, wr_en, rd_en, sclk, mosi, ss_n;
  logic [7:0] addr, din;
  logic [7:0] dout;
  logic       miso, miso_oe;

  spi_slave_top #(.ADDR_LSB(0), .OPT_MEM_ADDR_BITS(1), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
    .wr_en(wr_en), .rd_en(rd_en), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t       cpuQ[$];
  logic [7:0] misoExpQ[$];
  logic [7:0] misoActQ[$];
  event       misoEv;
  int         nCompared = 0;
  int         nMismatched = 0;

  logic [7:0] mTx, mRx;
  logic       mRxValid, mOverrun, mTxLoaded, mCpol, mCpha, mEn;
  logic [7:0] frameMosi[4];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%02h required 0x%02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] modelCon();
    return {1'b0, mTxLoaded, mOverrun, mRxValid, mEn, mCpha, mCpol, 1'b0};
  endfunction

  task automatic modelReset();
    mTx = 8'h00; mRx = 8'h00;
    mRxValid = 1'b0; mOverrun = 1'b0; mTxLoaded = 1'b0;
    mCpol = 1'b0; mCpha = 1'b0; mEn = 1'b0;
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpuWrite(input logic [1:0] loc, input logic [7:0] d);
    addr = {6'b0, loc}; din = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    case (loc)
      2'd0: begin
        mCpol = d[1]; mCpha = d[2]; mEn = d[3];
        if (!d[5]) mOverrun = 1'b0;
      end
      2'd1: begin mTx = d; mTxLoaded = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic cpuRead(input logic [1:0] loc, input string name);
    exp_t e;
    e.name = name;
    case (loc)
      2'd0: e.val = modelCon();
      2'd1: e.val = mTx;
      2'd2: e.val = mRx;
      default: e.val = 8'h00;
    endcase
    cpuQ.push_back(e);
    if (loc == 2'd2) mRxValid = 1'b0;
    addr = {6'b0, loc}; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Writing 1 to bit5 keeps any pending overrun intact
  task automatic setMode(input logic cpol, input logic cpha);
    cpuWrite(2'd0, {2'b00, 1'b1, 1'b0, 1'b1, cpha, cpol, 1'b0});
    sclk = cpol;
    waitClk(6);
  endtask

  task automatic xferBits(input logic [7:0] tx, input int nb, input bit midWr,
                          input logic [7:0] midVal, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      int bi = 7 - i;
      if (!mCpha) begin
        mosi = tx[bi];
        waitClk(HP);
        rx[bi] = miso;
        sclk = ~mCpol;
        waitClk(HP);
        sclk = mCpol;
      end else begin
        waitClk(HP);
        sclk = ~mCpol;
        mosi = tx[bi];
        waitClk(HP);
        rx[bi] = miso;
        sclk = mCpol;
      end
      if (midWr && i == 3) cpuWrite(2'd1, midVal);
    end
  endtask

  task automatic applyStimulus(input int n, input bit midWr, input logic [7:0] midVal);
    logic [7:0] curTx, got;
    ss_n = 1'b0;
    curTx = mTx;
    mTxLoaded = 1'b0;
    waitClk(HP);
    for (int b = 0; b < n; b++) begin
      misoExpQ.push_back(curTx);
      xferBits(frameMosi[b], 8, midWr && b == 0, midVal, got);
      misoActQ.push_back(got);
      -> misoEv;
      if (mRxValid) mOverrun = 1'b1;
      mRx = frameMosi[b];
      mRxValid = 1'b1;
      curTx = mTx;
      mTxLoaded = 1'b0;
    end
    waitClk(HP);
    ss_n = 1'b1;
    waitClk(8);
  endtask

  exp_t monE;
  initial begin
    forever begin
      @(posedge clk);
      if (rd_en === 1'b1 && wr_en === 1'b0) begin
        @(negedge clk);
        if (cpuQ.size() == 0) begin
          nCompared++; nMismatched++;
          $display("[TB] FAIL unexpected read: got 0x%02h required no read", dout);
        end else begin
          monE = cpuQ.pop_front();
          checkOutput(monE.name, dout, monE.val);
        end
      end
    end
  end

  logic [7:0] monAct;
  initial begin
    forever begin
      @(misoEv);
      while (misoActQ.size() > 0) begin
        monAct = misoActQ.pop_front();
        if (misoExpQ.size() == 0) begin
          nCompared++; nMismatched++;
          $display("[TB] FAIL master rx: got 0x%02h required no byte", monAct);
        end else begin
          checkOutput("master rx", monAct, misoExpQ.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] got, holdVal;
    int k;
    logic [1:0] modes[3];
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 8'h00; din = 8'h00;
    sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    modelReset();
    waitClk(3);
    checkOutput("reset dout", dout, 8'h00);
    checkOutput("reset miso", 8'(miso), 8'h00);
    checkOutput("reset miso_oe", 8'(miso_oe), 8'h00);
    reset_n = 1'b1;
    waitClk(3);
    cpuRead(2'd0, "reset SSPCON");
    cpuRead(2'd1, "reset SSPTX");
    cpuRead(2'd2, "reset SSPRX");

    $display("[TB] mode 0 single byte");
    setMode(1'b0, 1'b0);
    cpuWrite(2'd1, 8'hA5);
    frameMosi[0] = 8'h3C;
    applyStimulus(1, 1'b0, 8'h00);
    cpuRead(2'd0, "mode0 SSPCON after frame");
    cpuRead(2'd2, "mode0 SSPRX");
    cpuRead(2'd0, "mode0 SSPCON after read");

    $display("[TB] modes 3, 1, 2");
    modes[0] = 2'd3; modes[1] = 2'd1; modes[2] = 2'd2;
    for (int m = 0; m < 3; m++) begin
      setMode(modes[m][1], modes[m][0]);
      cpuWrite(2'd1, 8'h81);
      frameMosi[0] = 8'h7E;
      applyStimulus(1, 1'b0, 8'h00);
      cpuRead(2'd2, "mode SSPRX");
      cpuRead(2'd0, "mode SSPCON");
    end

    $display("[TB] continuous two-byte frame");
    setMode(1'b0, 1'b0);
    cpuWrite(2'd1, 8'hC3);
    frameMosi[0] = 8'h11; frameMosi[1] = 8'h22;
    applyStimulus(2, 1'b1, 8'h55);
    cpuRead(2'd0, "continuous SSPCON overrun");
    cpuRead(2'd2, "continuous SSPRX");
    cpuWrite(2'd0, 8'h08);
    cpuRead(2'd0, "overrun cleared");

    $display("[TB] abort after 5 bits");
    setMode(1'b0, 1'b0);
    cpuWrite(2'd1, 8'h5A);
    ss_n = 1'b0;
    mTxLoaded = 1'b0;
    waitClk(HP);
    xferBits(8'hF0, 5, 1'b0, 8'h00, got);
    ss_n = 1'b1;
    k = 0;
    while (miso_oe !== 1'b0 && k < SYNC + 2) begin
      @(negedge clk);
      k++;
    end
    checkOutput("abort miso_oe", 8'(miso_oe), 8'h00);
    waitClk(4);
    cpuRead(2'd0, "abort SSPCON");
    cpuRead(2'd2, "abort SSPRX unchanged");
    cpuWrite(2'd1, 8'h3B);
    frameMosi[0] = 8'h96;
    applyStimulus(1, 1'b0, 8'h00);
    cpuRead(2'd2, "post-abort SSPRX");

    $display("[TB] reset mid-transfer");
    setMode(1'b0, 1'b0);
    cpuWrite(2'd1, 8'hFF);
    ss_n = 1'b0;
    waitClk(HP);
    xferBits(8'hC0, 3, 1'b0, 8'h00, got);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset miso", 8'(miso), 8'h00);
    checkOutput("midreset miso_oe", 8'(miso_oe), 8'h00);
    checkOutput("midreset dout", dout, 8'h00);
    waitClk(2);
    modelReset();
    reset_n = 1'b1;
    ss_n = 1'b1; sclk = 1'b0;
    waitClk(6);
    ss_n = 1'b0;
    waitClk(8);
    checkOutput("disabled no entry miso_oe", 8'(miso_oe), 8'h00);
    cpuRead(2'd0, "post-reset SSPCON");
    cpuRead(2'd1, "post-reset SSPTX");
    cpuRead(2'd2, "post-reset SSPRX");
    ss_n = 1'b1;
    waitClk(4);

    $display("[TB] bus corners");
    cpuWrite(2'd1, 8'h42);
    cpuRead(2'd1, "SSPTX readback");
    waitClk(1);
    holdVal = 8'h42;
    addr = 8'h01; din = 8'h99; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    mTx = 8'h99; mTxLoaded = 1'b1;
    checkOutput("wr+rd dout hold", dout, holdVal);
    cpuRead(2'd1, "wr+rd SSPTX");
    waitClk(3);
    checkOutput("idle dout hold", dout, 8'h99);
    cpuWrite(2'd3, 8'hFF);
    cpuRead(2'd3, "addr 11 read");
    cpuRead(2'd0, "SSPCON after addr 11 write");

    $display("[TB] randomized frames");
    for (int it = 0; it < 8; it++) begin
      int n;
      setMode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) cpuWrite(2'd1, 8'($urandom));
      n = $urandom_range(1, 3);
      for (int b = 0; b < 4; b++) frameMosi[b] = 8'($urandom);
      applyStimulus(n, 1'b0, 8'h00);
      cpuRead(2'd0, "random SSPCON");
      if ($urandom_range(0, 1) == 1) cpuRead(2'd2, "random SSPRX");
      if (mOverrun && $urandom_range(0, 1) == 1)
        cpuWrite(2'd0, {2'b00, 1'b0, 1'b0, 1'b1, mCpha, mCpol, 1'b0});
    end

    waitClk(10);
    checkOutput("cpu queue drained", 8'(cpuQ.size()), 8'h00);
    checkOutput("master queue drained", 8'(misoExpQ.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
